// File: rtl/karatsuba_pkg.sv
// Shared types and constants for the Karatsuba multiplier datapath and its accumulator back end.
package karatsuba_pkg;

   localparam int unsigned PROD_W    = 16;
   localparam int unsigned DEF_COUNT = 4;
   localparam int unsigned DEF_ACC_W = 24;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } acc_state_t;

endpackage : karatsuba_pkg

// File: rtl/acc_adder.sv
// Unsigned ACC_W-bit + PROD_W-bit adder with carry-out, purely combinational.
module acc_adder
   import karatsuba_pkg::*;
#(
   parameter int unsigned ACC_W = DEF_ACC_W
) (
   input  logic [ACC_W-1:0]  acc,
   input  logic [PROD_W-1:0] addend,
   output logic [ACC_W-1:0]  sum_c,
   output logic              carry_c
);

   localparam int unsigned SUM_W = ACC_W + 1;

   logic [SUM_W-1:0] total;

   assign total   = SUM_W'(acc) + SUM_W'(addend);
   assign sum_c   = total[ACC_W-1:0];
   assign carry_c = total[ACC_W];

endmodule : acc_adder

// File: rtl/karatsuba_accumulator.sv
// Sums batches of COUNT unsigned products and presents each batch sum with a sticky overflow flag.
module karatsuba_accumulator
   import karatsuba_pkg::*;
#(
   parameter int unsigned COUNT = DEF_COUNT,
   parameter int unsigned ACC_W = DEF_ACC_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clear,
   input  logic [PROD_W-1:0] prod,
   input  logic              prod_valid,
   output logic              prod_ready,
   output logic [ACC_W-1:0]  sum,
   output logic              sum_valid,
   input  logic              sum_ready,
   output logic              sum_overflow,
   output logic              busy
);

   localparam int unsigned CNT_W = $clog2(COUNT + 1);

   acc_state_t       state, state_nxt;
   logic [ACC_W-1:0] acc, acc_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             ovf, ovf_nxt;
   logic             accept;
   logic [ACC_W-1:0] add_sum;
   logic             add_carry;

   acc_adder #(
      .ACC_W (ACC_W)
   ) u_acc_adder (
      .acc     (acc),
      .addend  (prod),
      .sum_c   (add_sum),
      .carry_c (add_carry)
   );

   assign accept = prod_valid && (state != ST_HOLD);

   // Handshake flags decode straight from the state register, so no input reaches an output.
   assign prod_ready   = (state != ST_HOLD);
   assign sum_valid    = (state == ST_HOLD);
   assign busy         = (state != ST_IDLE);
   assign sum          = acc;
   assign sum_overflow = ovf;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Clear wins over any accept or sum handshake in the same cycle.
   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      cnt_nxt   = cnt;
      ovf_nxt   = ovf;
      if (clear) begin
         state_nxt = ST_IDLE;
         acc_nxt   = '0;
         cnt_nxt   = '0;
         ovf_nxt   = 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  acc_nxt   = ACC_W'(prod);
                  cnt_nxt   = CNT_W'(1);
                  ovf_nxt   = 1'b0;
                  state_nxt = (COUNT == 1) ? ST_HOLD : ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               if (accept) begin
                  acc_nxt = add_sum;
                  ovf_nxt = ovf | add_carry;
                  cnt_nxt = cnt + CNT_W'(1);
                  if (cnt == CNT_W'(COUNT - 1)) begin
                     state_nxt = ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (sum_ready) begin
                  state_nxt = ST_IDLE;
                  acc_nxt   = '0;
                  cnt_nxt   = '0;
                  ovf_nxt   = 1'b0;
               end
            end
            default: begin
               state_nxt = ST_IDLE;
               acc_nxt   = '0;
               cnt_nxt   = '0;
               ovf_nxt   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else begin
         acc <= acc_nxt;
         cnt <= cnt_nxt;
         ovf <= ovf_nxt;
      end
   end

endmodule : karatsuba_accumulator

// File: tb/tb_karatsuba_accumulator.sv
// Directed bench for karatsuba_accumulator across COUNT=4/ACC_W=24, COUNT=2/ACC_W=16 and COUNT=1.
module tb_karatsuba_accumulator;

   logic clock;
   logic reset;

   logic        a_clear, a_prod_valid, a_prod_ready, a_sum_valid, a_sum_ready, a_sum_overflow, a_busy;
   logic [15:0] a_prod;
   logic [23:0] a_sum;

   logic        b_clear, b_prod_valid, b_prod_ready, b_sum_valid, b_sum_ready, b_sum_overflow, b_busy;
   logic [15:0] b_prod;
   logic [15:0] b_sum;

   logic        c_clear, c_prod_valid, c_prod_ready, c_sum_valid, c_sum_ready, c_sum_overflow, c_busy;
   logic [15:0] c_prod;
   logic [23:0] c_sum;

   int errors = 0;
   int checks = 0;

   karatsuba_accumulator #(.COUNT(4), .ACC_W(24)) dut_a (
      .clock(clock), .reset(reset), .clear(a_clear), .prod(a_prod), .prod_valid(a_prod_valid),
      .prod_ready(a_prod_ready), .sum(a_sum), .sum_valid(a_sum_valid), .sum_ready(a_sum_ready),
      .sum_overflow(a_sum_overflow), .busy(a_busy));

   karatsuba_accumulator #(.COUNT(2), .ACC_W(16)) dut_b (
      .clock(clock), .reset(reset), .clear(b_clear), .prod(b_prod), .prod_valid(b_prod_valid),
      .prod_ready(b_prod_ready), .sum(b_sum), .sum_valid(b_sum_valid), .sum_ready(b_sum_ready),
      .sum_overflow(b_sum_overflow), .busy(b_busy));

   karatsuba_accumulator #(.COUNT(1), .ACC_W(24)) dut_c (
      .clock(clock), .reset(reset), .clear(c_clear), .prod(c_prod), .prod_valid(c_prod_valid),
      .prod_ready(c_prod_ready), .sum(c_sum), .sum_valid(c_sum_valid), .sum_ready(c_sum_ready),
      .sum_overflow(c_sum_overflow), .busy(c_busy));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic a_push(input logic [15:0] v);
      a_prod_valid = 1'b1;
      a_prod       = v;
      tick();
      a_prod_valid = 1'b0;
   endtask

   task automatic b_push(input logic [15:0] v);
      b_prod_valid = 1'b1;
      b_prod       = v;
      tick();
      b_prod_valid = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      checks++; if (a_prod_ready !== 1'b1) begin errors++; $display("FAIL reset_prod_ready got %b exp 1", a_prod_ready); end
      checks++; if (a_sum_valid !== 1'b0) begin errors++; $display("FAIL reset_sum_valid got %b exp 0", a_sum_valid); end
      checks++; if (a_sum !== 24'h0) begin errors++; $display("FAIL reset_sum got %h exp 000000", a_sum); end
      checks++; if (a_sum_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", a_sum_overflow); end
      checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", a_busy); end
      tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      a_sum_ready = 1'b1;
      a_push(16'h0001);
      checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL basic_busy_accum got %b exp 1", a_busy); end
      a_push(16'h0002);
      a_push(16'h0003);
      a_push(16'h0004);
      checks++; if (a_sum_valid !== 1'b1) begin errors++; $display("FAIL basic_sum_valid got %b exp 1", a_sum_valid); end
      checks++; if (a_sum !== 24'h00000A) begin errors++; $display("FAIL basic_sum got %h exp 00000a", a_sum); end
      checks++; if (a_sum_overflow !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b exp 0", a_sum_overflow); end
      checks++; if (a_prod_ready !== 1'b0) begin errors++; $display("FAIL basic_hold_ready got %b exp 0", a_prod_ready); end
      tick();
      checks++; if (a_sum_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_one_cycle got %b exp 0", a_sum_valid); end
      checks++; if (a_prod_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after got %b exp 1", a_prod_ready); end
      checks++; if (a_sum !== 24'h0) begin errors++; $display("FAIL basic_idle_sum got %h exp 000000", a_sum); end
   endtask

   task automatic test_backpressure();
      a_sum_ready = 1'b0;
      for (int i = 0; i < 4; i++) a_push(16'h00E1);
      a_prod_valid = 1'b1;
      a_prod       = 16'hFFFF;
      for (int k = 0; k < 5; k++) begin
         checks++; if (a_sum_valid !== 1'b1) begin errors++; $display("FAIL bp_sum_valid[%0d] got %b exp 1", k, a_sum_valid); end
         checks++; if (a_prod_ready !== 1'b0) begin errors++; $display("FAIL bp_prod_ready[%0d] got %b exp 0", k, a_prod_ready); end
         checks++; if (a_sum !== 24'h000384) begin errors++; $display("FAIL bp_sum[%0d] got %h exp 000384", k, a_sum); end
         tick();
      end
      a_sum_ready = 1'b1;
      checks++; if (a_sum_valid !== 1'b1) begin errors++; $display("FAIL bp_still_valid got %b exp 1", a_sum_valid); end
      tick();
      checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL bp_idle_busy got %b exp 0", a_busy); end
      checks++; if (a_sum !== 24'h0) begin errors++; $display("FAIL bp_idle_sum got %h exp 000000", a_sum); end
      checks++; if (a_prod_ready !== 1'b1) begin errors++; $display("FAIL bp_idle_ready got %b exp 1", a_prod_ready); end
      tick();
      a_prod_valid = 1'b0;
      checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL bp_ffff_accepted got %b exp 1", a_busy); end
      a_clear = 1'b1;
      tick();
      a_clear = 1'b0;
      checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL bp_clear_busy got %b exp 0", a_busy); end
   endtask

   task automatic test_clear();
      a_sum_ready = 1'b1;
      a_push(16'h0010);
      a_push(16'h0020);
      a_clear = 1'b1;
      a_push(16'h0030);
      a_clear = 1'b0;
      checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL clr_busy got %b exp 0", a_busy); end
      checks++; if (a_sum !== 24'h0) begin errors++; $display("FAIL clr_sum got %h exp 000000", a_sum); end
      checks++; if (a_sum_valid !== 1'b0) begin errors++; $display("FAIL clr_sum_valid got %b exp 0", a_sum_valid); end
      for (int i = 0; i < 4; i++) a_push(16'h0001);
      checks++; if (a_sum_valid !== 1'b1) begin errors++; $display("FAIL clr_next_valid got %b exp 1", a_sum_valid); end
      checks++; if (a_sum !== 24'h000004) begin errors++; $display("FAIL clr_next_sum got %h exp 000004", a_sum); end
      tick();
   endtask

   task automatic test_gaps();
      a_sum_ready = 1'b1;
      a_push(16'h0003);
      tick();
      a_push(16'h0004);
      tick();
      tick();
      checks++; if (a_sum_valid !== 1'b0) begin errors++; $display("FAIL gap_early_valid got %b exp 0", a_sum_valid); end
      a_push(16'h0005);
      a_push(16'h0006);
      checks++; if (a_sum_valid !== 1'b1) begin errors++; $display("FAIL gap_valid got %b exp 1", a_sum_valid); end
      checks++; if (a_sum !== 24'h000012) begin errors++; $display("FAIL gap_sum got %h exp 000012", a_sum); end
      tick();
   endtask

   task automatic test_async_reset();
      a_sum_ready = 1'b0;
      for (int i = 1; i <= 4; i++) a_push(16'(i));
      checks++; if (a_sum !== 24'h00000A) begin errors++; $display("FAIL ar_hold_sum got %h exp 00000a", a_sum); end
      #2;
      reset = 1'b0;
      #1;
      checks++; if (a_sum_valid !== 1'b0) begin errors++; $display("FAIL ar_sum_valid got %b exp 0", a_sum_valid); end
      checks++; if (a_sum !== 24'h0) begin errors++; $display("FAIL ar_sum got %h exp 000000", a_sum); end
      checks++; if (a_prod_ready !== 1'b1) begin errors++; $display("FAIL ar_prod_ready got %b exp 1", a_prod_ready); end
      #1;
      reset = 1'b1;
      tick();
      a_sum_ready = 1'b1;
      for (int i = 5; i <= 8; i++) a_push(16'(i));
      checks++; if (a_sum_valid !== 1'b1) begin errors++; $display("FAIL ar_fresh_valid got %b exp 1", a_sum_valid); end
      checks++; if (a_sum !== 24'h00001A) begin errors++; $display("FAIL ar_fresh_sum got %h exp 00001a", a_sum); end
      tick();
   endtask

   task automatic test_overflow();
      b_sum_ready = 1'b1;
      b_push(16'hFFFF);
      b_push(16'h0002);
      checks++; if (b_sum_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid got %b exp 1", b_sum_valid); end
      checks++; if (b_sum !== 16'h0001) begin errors++; $display("FAIL ovf_sum got %h exp 0001", b_sum); end
      checks++; if (b_sum_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", b_sum_overflow); end
      tick();
      b_push(16'h0001);
      b_push(16'h0001);
      checks++; if (b_sum !== 16'h0002) begin errors++; $display("FAIL ovf_next_sum got %h exp 0002", b_sum); end
      checks++; if (b_sum_overflow !== 1'b0) begin errors++; $display("FAIL ovf_next_flag got %b exp 0", b_sum_overflow); end
      tick();
   endtask

   task automatic test_single();
      c_sum_ready  = 1'b0;
      c_prod_valid = 1'b1;
      c_prod       = 16'hFE01;
      tick();
      c_prod_valid = 1'b0;
      checks++; if (c_sum_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", c_sum_valid); end
      checks++; if (c_sum !== 24'h00FE01) begin errors++; $display("FAIL single_sum got %h exp 00fe01", c_sum); end
      checks++; if (c_sum_overflow !== 1'b0) begin errors++; $display("FAIL single_ovf got %b exp 0", c_sum_overflow); end
      c_sum_ready = 1'b1;
      tick();
      checks++; if (c_sum_valid !== 1'b0) begin errors++; $display("FAIL single_done got %b exp 0", c_sum_valid); end
   endtask

   initial begin
      reset = 1'b0;
      a_clear = 1'b0; a_prod = '0; a_prod_valid = 1'b0; a_sum_ready = 1'b0;
      b_clear = 1'b0; b_prod = '0; b_prod_valid = 1'b0; b_sum_ready = 1'b0;
      c_clear = 1'b0; c_prod = '0; c_prod_valid = 1'b0; c_sum_ready = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_clear();
      test_gaps();
      test_async_reset();
      test_overflow();
      test_single();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_karatsuba_accumulator
